pipe_skid_reg: RTL and testbench

- Parametrised pipeline register stage; successor to the fixed-width enable flops.
- Adds a valid/ready handshake, a 2-entry skid buffer so upstream ready is registered, and a synchronous flush.
- Sits between pipeline stages, for example the value-decode stage and the display-load stage.
- Sustains one transfer per cycle with no combinational path from out_ready to in_ready.

---
 rtl/pipe_skid_reg.sv | 92 +++++++++
 tb/tb_pipe_skid_reg.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline register stage with valid/ready handshake and a 2-entry skid buffer.
// in_ready depends only on registered state plus flush/reset gating, so out_ready never reaches it combinationally.
module pipe_skid_reg #(
  parameter int unsigned            WIDTH       = 32,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept, take;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    in_ready  = (state_q != TWO) && !flush && !reset;
    out_valid = (state_q != EMPTY);
    out_data  = main_q;
    accept    = in_valid && in_ready;
    take      = out_valid && out_ready;
    case (state_q)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && take) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = TWO;
        end else if (take) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // accept is already blocked by flush; the skid->main move must be too,
        // so a flush leaves both data registers untouched.
        if (take && !flush) begin
          main_d  = skid_q;
          state_d = ONE;
        end else if (take) begin
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: queue-based reference model, directed scenarios, random traffic.
module tb_pipe_skid_reg;

  localparam int unsigned WIDTH = 32;
  localparam logic [WIDTH-1:0] RV = 32'hDEAD_BEEF;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q[$];

  pipe_skid_reg #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare outputs with the model, then advance the model to what the coming edge does.
  task automatic step(input bit iv, input logic [WIDTH-1:0] d, input bit ordy, input bit fl);
    bit m_ready, m_take;
    @(negedge clock);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    m_ready = (q.size() < 2) && !fl && !reset;
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("occupancy", {30'd0, occupancy}, q.size());
    chk("in_ready",  {31'd0, in_ready},  {31'd0, m_ready});
    if (q.size() != 0) chk("out_data", out_data, q[0]);
    m_take = (q.size() != 0) && ordy;
    if (fl) q.delete();
    else begin
      if (m_take) void'(q.pop_front());
      if (iv && m_ready) q.push_back(d);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_out_data",  out_data, 32'hDEAD_BEEF);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
    @(negedge clock); reset = 1'b0;

    // streaming
    for (int i = 1; i <= 4; i++) begin
      step(1, i, 1, 0);
      if (i > 1) begin
        chk("stream_data", out_data, i - 1);
        chk("stream_occ", {30'd0, occupancy}, 32'd1);
        chk("stream_rdy", {31'd0, in_ready}, 32'd1);
      end
    end
    step(0, 0, 1, 0); chk("stream_last", out_data, 32'd4);
    step(0, 0, 1, 0); chk("stream_empty", {30'd0, occupancy}, 32'd0);

    // backpressure
    step(1, 32'hA, 0, 0);
    step(1, 32'hB, 0, 0); chk("bp_occ1", {30'd0, occupancy}, 32'd1);
    step(0, 0, 0, 0);     chk("bp_occ2", {30'd0, occupancy}, 32'd2);
                          chk("bp_rdy0", {31'd0, in_ready}, 32'd0);
    step(0, 0, 1, 0);     chk("bp_A", out_data, 32'hA);
    step(0, 0, 1, 0);     chk("bp_B", out_data, 32'hB);
                          chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
    step(0, 0, 1, 0);     chk("bp_empty", {30'd0, occupancy}, 32'd0);

    // flush in TWO
    step(1, 32'hA, 0, 0);
    step(1, 32'hB, 0, 0);
    step(1, 32'hC, 0, 1); chk("fl_occ2", {30'd0, occupancy}, 32'd2);
    step(1, 32'hD, 0, 0); chk("fl_valid0", {31'd0, out_valid}, 32'd0);
                          chk("fl_occ0", {30'd0, occupancy}, 32'd0);
    step(0, 0, 1, 0);     chk("fl_D", out_data, 32'hD);
    step(0, 0, 0, 0);     chk("fl_drained", {30'd0, occupancy}, 32'd0);

    // simultaneous accept and take
    step(1, 32'h1111, 0, 0);
    step(1, 32'h2222, 1, 0); chk("sim_X", out_data, 32'h1111);
    step(0, 0, 0, 0);        chk("sim_Y", out_data, 32'h2222);
                             chk("sim_occ", {30'd0, occupancy}, 32'd1);
    step(0, 0, 1, 0);

    // asynchronous reset while holding two entries
    step(1, 32'hA, 0, 0);
    step(1, 32'hB, 0, 0);
    step(0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_occ",   {30'd0, occupancy}, 32'd0);
    chk("mrst_data",  out_data, 32'hDEAD_BEEF);
    chk("mrst_rdy",   {31'd0, in_ready}, 32'd0);
    q.delete();
    @(negedge clock); reset = 1'b0;
    step(1, 32'hE, 0, 0);
    step(0, 0, 1, 0); chk("mrst_E", out_data, 32'hE);
                      chk("mrst_occ1", {30'd0, occupancy}, 32'd1);

    // random traffic
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
